// File: rtl/sva_window_checker.sv
// Hardware checker for the property trig |-> ##[DMIN:DMAX] expr, evaluated only on sample_en strobes.
// Optional fail_cnt output and simulation fail log are enabled by defining SVA_FAIL_LOG_EN.
module sva_window_checker #(
   parameter int THREADS  = 4,
   parameter int DMIN     = 1,
   parameter int DMAX     = 4,
   parameter int TS_WIDTH = 16
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic                         sample_en,
   input  logic                         trig,
   input  logic                         expr,
   output logic                         succ,
   output logic [$clog2(THREADS+1)-1:0] succ_num,
   output logic                         fail,
   output logic [TS_WIDTH-1:0]          fail_ts,
   output logic                         overflow,
   output logic [$clog2(THREADS+1)-1:0] active_cnt,
   output logic                         busy
`ifdef SVA_FAIL_LOG_EN
   ,
   output logic [15:0]                  fail_cnt
`endif
);

   localparam int CW = $clog2(THREADS+1);
   localparam int AW = $clog2(DMAX+1);
   localparam logic [AW-1:0] L_DMIN = AW'(DMIN);
   localparam logic [AW-1:0] L_DMAX = AW'(DMAX);

   // Per-slot attempt state
   logic [THREADS-1:0]  r_valid;
   logic [AW-1:0]       r_age [THREADS];
   logic [TS_WIDTH-1:0] r_ts  [THREADS];
   logic [TS_WIDTH-1:0] r_timer;

   logic                r_succ;
   logic [CW-1:0]       r_succ_num;
   logic                r_fail;
   logic [TS_WIDTH-1:0] r_fail_ts;
   logic                r_overflow;
   logic [CW-1:0]       r_active_cnt;

   logic [AW-1:0]       w_eval_age [THREADS];
   logic [THREADS-1:0]  w_hit;
   logic [THREADS-1:0]  w_expire;

   logic [THREADS-1:0]  w_valid_nxt;
   logic [AW-1:0]       w_age_nxt [THREADS];
   logic [TS_WIDTH-1:0] w_ts_nxt  [THREADS];
   logic [CW-1:0]       w_succ_cnt;
   logic                w_fail_any;
   logic [TS_WIDTH-1:0] w_fail_ts_nxt;
   logic                w_alloc_done;
   logic                w_overflow;
   logic [CW-1:0]       w_active_nxt;

   // A slot is judged at the age it reaches on this sample, so a fresh attempt never sees its own trig sample.
   for (genvar g = 0; g < THREADS; g++) begin : g_slot
      assign w_eval_age[g] = r_age[g] + AW'(1);
      assign w_hit[g]      = r_valid[g] && expr &&
                             (w_eval_age[g] >= L_DMIN) && (w_eval_age[g] <= L_DMAX);
      assign w_expire[g]   = r_valid[g] && !w_hit[g] && (w_eval_age[g] == L_DMAX);
   end

   always_comb begin
      w_valid_nxt   = r_valid;
      w_age_nxt     = r_age;
      w_ts_nxt      = r_ts;
      w_succ_cnt    = '0;
      w_fail_any    = 1'b0;
      w_fail_ts_nxt = r_fail_ts;
      w_alloc_done  = 1'b0;
      w_active_nxt  = '0;

      for (int i = 0; i < THREADS; i++) begin
         if (w_hit[i]) begin
            w_valid_nxt[i] = 1'b0;
            w_succ_cnt     = w_succ_cnt + CW'(1);
         end else if (w_expire[i]) begin
            w_valid_nxt[i] = 1'b0;
            if (!w_fail_any) begin
               w_fail_any    = 1'b1;
               w_fail_ts_nxt = r_ts[i];
            end
         end else if (r_valid[i]) begin
            w_age_nxt[i] = w_eval_age[i];
         end
      end

      // Allocation looks at r_valid, so slots freed on this sample stay unavailable until the next one.
      for (int i = 0; i < THREADS; i++) begin
         if (trig && !r_valid[i] && !w_alloc_done) begin
            w_valid_nxt[i] = 1'b1;
            w_age_nxt[i]   = '0;
            w_ts_nxt[i]    = r_timer;
            w_alloc_done   = 1'b1;
         end
      end
      w_overflow = trig && !w_alloc_done;

      for (int i = 0; i < THREADS; i++) begin
         w_active_nxt = w_active_nxt + CW'(w_valid_nxt[i]);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < THREADS; i++) begin
            r_age[i] <= '0;
            r_ts[i]  <= '0;
         end
         r_timer      <= '0;
         r_succ       <= 1'b0;
         r_succ_num   <= '0;
         r_fail       <= 1'b0;
         r_fail_ts    <= '0;
         r_overflow   <= 1'b0;
         r_active_cnt <= '0;
      end else if (sample_en) begin
         r_valid      <= w_valid_nxt;
         r_age        <= w_age_nxt;
         r_ts         <= w_ts_nxt;
         r_timer      <= r_timer + TS_WIDTH'(1);
         r_succ       <= (w_succ_cnt != '0);
         r_succ_num   <= w_succ_cnt;
         r_fail       <= w_fail_any;
         r_fail_ts    <= w_fail_ts_nxt;
         r_overflow   <= w_overflow;
         r_active_cnt <= w_active_nxt;
      end else begin
         r_succ     <= 1'b0;
         r_succ_num <= '0;
         r_fail     <= 1'b0;
         r_overflow <= 1'b0;
      end
   end

   assign succ       = r_succ;
   assign succ_num   = r_succ_num;
   assign fail       = r_fail;
   assign fail_ts    = r_fail_ts;
   assign overflow   = r_overflow;
   assign active_cnt = r_active_cnt;
   assign busy       = (r_active_cnt != '0);

`ifdef SVA_FAIL_LOG_EN
   logic [15:0] r_fail_cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_fail_cnt <= '0;
      end else if (sample_en && w_fail_any && (r_fail_cnt != 16'hFFFF)) begin
         r_fail_cnt <= r_fail_cnt + 16'd1;
      end
   end

   assign fail_cnt = r_fail_cnt;

`ifndef SYNTHESIS
   always_ff @(posedge sys_clk) begin
      if (sys_rst_n && sample_en && w_fail_any) begin
         $display("FAIL ts=%0d", w_fail_ts_nxt);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_sva_window_checker.sv
// Bench for sva_window_checker: a directed vector table, reset sequences, and random traffic
// checked against an attempt-list reference model on two differently parameterised instances.
module tb_sva_window_checker;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   logic sample_en;
   logic trig;
   logic expr;

   logic        succ_o [2];
   logic [1:0]  num_o  [2];
   logic        fail_o [2];
   logic [3:0]  fts_o  [2];
   logic        ovf_o  [2];
   logic [1:0]  act_o  [2];
   logic        busy_o [2];
`ifdef SVA_FAIL_LOG_EN
   logic [15:0] fcnt_o [2];
`endif

   always #5 sys_clk = ~sys_clk;

   sva_window_checker #(.THREADS(2), .DMIN(1), .DMAX(3), .TS_WIDTH(4)) u_dut0 (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .sample_en  (sample_en),
      .trig       (trig),
      .expr       (expr),
      .succ       (succ_o[0]),
      .succ_num   (num_o[0]),
      .fail       (fail_o[0]),
      .fail_ts    (fts_o[0]),
      .overflow   (ovf_o[0]),
      .active_cnt (act_o[0]),
      .busy       (busy_o[0])
`ifdef SVA_FAIL_LOG_EN
      ,
      .fail_cnt   (fcnt_o[0])
`endif
   );

   sva_window_checker #(.THREADS(3), .DMIN(2), .DMAX(4), .TS_WIDTH(4)) u_dut1 (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .sample_en  (sample_en),
      .trig       (trig),
      .expr       (expr),
      .succ       (succ_o[1]),
      .succ_num   (num_o[1]),
      .fail       (fail_o[1]),
      .fail_ts    (fts_o[1]),
      .overflow   (ovf_o[1]),
      .active_cnt (act_o[1]),
      .busy       (busy_o[1])
`ifdef SVA_FAIL_LOG_EN
      ,
      .fail_cnt   (fcnt_o[1])
`endif
   );

   // Reference model: a list of live attempts, each remembering the sample number it started on.
   typedef struct {
      int dut;
      int slot;
      int start;
      int ts;
   } att_t;

   att_t att_q[$];
   int   p_dmin [2] = '{1, 2};
   int   p_dmax [2] = '{3, 4};
   int   p_th   [2] = '{2, 3};
   int   m_n    [2];
   int   e_succ [2];
   int   e_num  [2];
   int   e_fail [2];
   int   e_fts  [2];
   int   e_ovf  [2];
   int   e_act  [2];
   int   e_fcnt [2];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void model_reset();
      att_q.delete();
      for (int k = 0; k < 2; k++) begin
         m_n[k] = 0; e_succ[k] = 0; e_num[k] = 0; e_fail[k] = 0;
         e_fts[k] = 0; e_ovf[k] = 0; e_act[k] = 0; e_fcnt[k] = 0;
      end
   endfunction

   function automatic void model_step(int k, bit en, bit t, bit e);
      bit used [16];
      int nsucc;
      int fslot;
      int d;
      int found;
      e_succ[k] = 0; e_num[k] = 0; e_fail[k] = 0; e_ovf[k] = 0;
      if (!en) return;
      for (int j = 0; j < 16; j++) used[j] = 1'b0;
      foreach (att_q[j]) if (att_q[j].dut == k) used[att_q[j].slot] = 1'b1;
      nsucc = 0;
      fslot = 99;
      for (int j = att_q.size() - 1; j >= 0; j--) begin
         if (att_q[j].dut == k) begin
            d = m_n[k] - att_q[j].start;
            if (e && d >= p_dmin[k] && d <= p_dmax[k]) begin
               nsucc++;
               att_q.delete(j);
            end else if (d == p_dmax[k]) begin
               if (att_q[j].slot < fslot) begin
                  fslot    = att_q[j].slot;
                  e_fts[k] = att_q[j].ts;
               end
               att_q.delete(j);
            end
         end
      end
      if (t) begin
         found = -1;
         for (int s = 0; s < p_th[k]; s++) if (!used[s] && found < 0) found = s;
         if (found < 0) e_ovf[k] = 1;
         else att_q.push_back('{dut: k, slot: found, start: m_n[k], ts: m_n[k] % 16});
      end
      e_succ[k] = (nsucc > 0) ? 1 : 0;
      e_num[k]  = nsucc;
      e_fail[k] = (fslot != 99) ? 1 : 0;
      if (e_fail[k] == 1 && e_fcnt[k] < 65535) e_fcnt[k]++;
      m_n[k]++;
      e_act[k] = 0;
      foreach (att_q[j]) if (att_q[j].dut == k) e_act[k]++;
   endfunction

   task automatic chk(string name, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_model(int k, string tag);
      chk($sformatf("%s_d%0d_succ", tag, k), int'(succ_o[k]), e_succ[k]);
      chk($sformatf("%s_d%0d_num", tag, k),  int'(num_o[k]),  e_num[k]);
      chk($sformatf("%s_d%0d_fail", tag, k), int'(fail_o[k]), e_fail[k]);
      chk($sformatf("%s_d%0d_fts", tag, k),  int'(fts_o[k]),  e_fts[k]);
      chk($sformatf("%s_d%0d_ovf", tag, k),  int'(ovf_o[k]),  e_ovf[k]);
      chk($sformatf("%s_d%0d_act", tag, k),  int'(act_o[k]),  e_act[k]);
      chk($sformatf("%s_d%0d_busy", tag, k), int'(busy_o[k]), (e_act[k] != 0) ? 1 : 0);
`ifdef SVA_FAIL_LOG_EN
      chk($sformatf("%s_d%0d_fcnt", tag, k), int'(fcnt_o[k]), e_fcnt[k]);
`endif
   endtask

   // Drive one clock's worth of inputs, advance the model, and sample outputs 1 time unit after the edge.
   task automatic step(int en, int t, int e, bit chk0, string tag);
      sample_en = (en != 0);
      trig      = (t != 0);
      expr      = (e != 0);
      model_step(0, en != 0, t != 0, e != 0);
      model_step(1, en != 0, t != 0, e != 0);
      @(posedge sys_clk);
      #1;
      if (chk0) check_model(0, tag);
      check_model(1, tag);
   endtask

   typedef struct {
      int en, tr, ex, succ, num, fail, fts, ovf, act;
   } vec_t;

   vec_t tbl[$];

   initial begin
      sys_rst_n = 1'b0;
      sample_en = 1'b0;
      trig      = 1'b0;
      expr      = 1'b0;
      model_reset();
      #2;
      check_model(0, "reset");
      check_model(1, "reset");
      #10;
      sys_rst_n = 1'b1;

      // en tr ex | succ num fail fts ovf act   (DUT0: THREADS=2, DMIN=1, DMAX=3, 4-bit timer)
      tbl.push_back('{1,1,0, 0,0,0,0, 0,1});
      tbl.push_back('{1,0,0, 0,0,0,0, 0,1});
      tbl.push_back('{1,0,1, 1,1,0,0, 0,0});
      tbl.push_back('{1,1,1, 0,0,0,0, 0,1});
      tbl.push_back('{1,0,0, 0,0,0,0, 0,1});
      tbl.push_back('{1,0,0, 0,0,0,0, 0,1});
      tbl.push_back('{1,0,0, 0,0,1,3, 0,0});
      tbl.push_back('{1,0,0, 0,0,0,3, 0,0});
      tbl.push_back('{1,1,0, 0,0,0,3, 0,1});
      tbl.push_back('{1,1,0, 0,0,0,3, 0,2});
      tbl.push_back('{1,1,0, 0,0,0,3, 1,2});
      tbl.push_back('{1,0,0, 0,0,1,8, 0,1});
      tbl.push_back('{1,0,0, 0,0,1,9, 0,0});
      tbl.push_back('{1,0,0, 0,0,0,9, 0,0});
      tbl.push_back('{1,1,0, 0,0,0,9, 0,1});
      tbl.push_back('{1,1,0, 0,0,0,9, 0,2});
      tbl.push_back('{1,0,1, 1,2,0,9, 0,0});
      tbl.push_back('{1,1,0, 0,0,0,9, 0,1});
      for (int i = 0; i < 5; i++) tbl.push_back('{0,0,1, 0,0,0,9, 0,1});
      tbl.push_back('{1,0,0, 0,0,0,9, 0,1});
      tbl.push_back('{1,0,0, 0,0,0,9, 0,1});
      tbl.push_back('{1,0,0, 0,0,1,1, 0,0});
      tbl.push_back('{1,1,0, 0,0,0,1, 0,1});
      tbl.push_back('{1,0,0, 0,0,0,1, 0,1});
      tbl.push_back('{1,0,0, 0,0,0,1, 0,1});
      tbl.push_back('{1,0,1, 1,1,0,1, 0,0});
      tbl.push_back('{1,1,0, 0,0,0,1, 0,1});
      tbl.push_back('{1,1,0, 0,0,0,1, 0,2});
      tbl.push_back('{1,0,0, 0,0,0,1, 0,2});
      tbl.push_back('{1,1,0, 0,0,1,9, 1,1});
      tbl.push_back('{1,1,0, 0,0,1,10, 0,1});
      tbl.push_back('{1,0,1, 1,1,0,10, 0,0});

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].en, tbl[i].tr, tbl[i].ex, 1'b0, $sformatf("v%0d", i));
         chk($sformatf("v%0d_succ", i), int'(succ_o[0]), tbl[i].succ);
         chk($sformatf("v%0d_num", i),  int'(num_o[0]),  tbl[i].num);
         chk($sformatf("v%0d_fail", i), int'(fail_o[0]), tbl[i].fail);
         chk($sformatf("v%0d_fts", i),  int'(fts_o[0]),  tbl[i].fts);
         chk($sformatf("v%0d_ovf", i),  int'(ovf_o[0]),  tbl[i].ovf);
         chk($sformatf("v%0d_act", i),  int'(act_o[0]),  tbl[i].act);
         chk($sformatf("v%0d_busy", i), int'(busy_o[0]), (tbl[i].act != 0) ? 1 : 0);
      end

      // Fresh reset: first sample after release is timer 0, so the expiring attempt reports ts 0.
      sys_rst_n = 1'b0;
      model_reset();
      #2;
      check_model(0, "rst2");
      check_model(1, "rst2");
      sys_rst_n = 1'b1;
      step(1, 1, 1, 1'b1, "s37a");
      step(1, 0, 0, 1'b1, "s37b");
      step(1, 0, 0, 1'b1, "s37c");
      step(1, 0, 0, 1'b1, "s37d");
      chk("s37_fail", int'(fail_o[0]), 1);
      chk("s37_fail_ts", int'(fts_o[0]), 0);

      // Reset asserted between edges while an attempt is live: outputs clear at once, no fail follows.
      step(1, 1, 0, 1'b1, "s41a");
      chk("s41_busy_before", int'(busy_o[0]), 1);
      #4;
      sys_rst_n = 1'b0;
      model_reset();
      #1;
      check_model(0, "s41_async");
      check_model(1, "s41_async");
      #2;
      sys_rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 1'b1, $sformatf("s41_post%0d", i));
         chk($sformatf("s41_nofail%0d", i), int'(fail_o[0]), 0);
      end

      // Random traffic on both instances against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0) ? 1 : 0,
              int'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? 1 : 0,
              1'b1, $sformatf("r%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sva_window_checker.md
SVA_WINDOW_CHECKER -- requirements
Module: sva_window_checker

Interface
REQ-001 The block SHALL have parameter THREADS, default 4: maximum concurrent property attempts (1..16).
REQ-002 The block SHALL have parameter DMIN, default 1: earliest consequent offset in samples (1 <= DMIN <= DMAX).
REQ-003 The block SHALL have parameter DMAX, default 4: latest consequent offset in samples (DMAX <= 255).
REQ-004 The block SHALL have parameter TS_WIDTH, default 16: timestamp width.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port sample_en, input, 1 bit: user-clock sample strobe; only edges with sample_en=1 are evaluated.
REQ-008 The block SHALL have port trig, input, 1 bit: antecedent of trig |-> ##[DMIN:DMAX] expr.
REQ-009 The block SHALL have port expr, input, 1 bit: consequent.
REQ-010 The block SHALL have port succ, output, 1 bit: pulse; at least one attempt matched.
REQ-011 The block SHALL have port succ_num, output, $clog2(THREADS+1) bits: number of attempts matched at this sample.
REQ-012 The block SHALL have port fail, output, 1 bit: pulse; an attempt expired unmatched.
REQ-013 The block SHALL have port fail_ts, output, TS_WIDTH bits: start timestamp of the failing attempt.
REQ-014 The block SHALL have port overflow, output, 1 bit: pulse; trig was dropped because no slot was free.
REQ-015 The block SHALL have port active_cnt, output, $clog2(THREADS+1) bits: number of live attempts.
REQ-016 The block SHALL have port busy, output, 1 bit: active_cnt != 0.

Function
REQ-017 Timer: TS_WIDTH counter SHALL increment by 1 on each sampled edge and wrap modulo 2^TS_WIDTH.
REQ-018 Slot state SHALL be: valid, age (width $clog2(DMAX+1)), ts.
REQ-019 On a sampled edge, each valid slot SHALL take age+1 as its evaluation age a.
REQ-020 If DMIN <= a <= DMAX and expr=1, the slot SHALL succeed and be freed.
REQ-021 Else if a == DMAX, the slot SHALL fail and be freed.
REQ-022 Otherwise the slot SHALL store age=a.
REQ-023 On a sampled edge with trig=1, the lowest-index slot free before this edge SHALL be loaded with valid=1, age=0, ts=current timer; expr at that same sample SHALL NOT count for it.
REQ-024 A slot freed at an edge SHALL NOT be reallocated at that same edge.
REQ-025 If trig=1 and no slot is free, overflow SHALL pulse and the attempt SHALL be dropped, with no fail reported.
REQ-026 succ, succ_num, fail, fail_ts and overflow SHALL be registered at the sampled edge and held for exactly one sys_clk cycle; they SHALL be 0 on cycles following a non-sampled edge. fail_ts SHALL hold its last value when fail=0.
REQ-027 Multiple simultaneous successes SHALL set succ_num to the count of successes.
REQ-028 Simultaneous fails SHALL be impossible, since starts differ; if they occur, fail_ts SHALL report the lowest-index slot.
REQ-029 active_cnt SHALL reflect slot state after the edge (allocations included, frees excluded).
REQ-030 sample_en=0 SHALL freeze all slots and the timer.

Reset
REQ-031 On sys_rst_n=0, asynchronously: all slots invalid; timer, succ, succ_num, fail, fail_ts, overflow, active_cnt and busy SHALL be 0.
REQ-032 Assertion of sys_rst_n=0 mid-attempt SHALL discard attempts silently with no fail.
REQ-033 The first sampled edge after sys_rst_n rises SHALL be timer 0.

Configuration
REQ-034 With macro SVA_FAIL_LOG_EN defined, the block SHALL add output fail_cnt (16 bits, saturating at 0xFFFF, reset 0), incremented per fail, and SHALL $display "FAIL ts=%0d" on each fail in simulation.
REQ-035 Without SVA_FAIL_LOG_EN, fail_cnt and the $display SHALL be absent and all other behaviour SHALL be identical.

Verification (DMIN=1, DMAX=3, THREADS=2, sample_en=1 unless stated)
REQ-036 Scenario: trig@s0, expr=1@s2 -> succ=1, succ_num=1 after s2; active_cnt 1 then 0.
REQ-037 Scenario: trig@s0, expr=0@s1..s3 -> fail=1 after s3, fail_ts=0; expr=1@s0 only SHALL NOT cause succ.
REQ-038 Scenario: trig@s0,s1,s2, expr=0 -> overflow after s2; fails after s3 (fail_ts=0) and s4 (fail_ts=1); none for s2.
REQ-039 Scenario: trig@s0,s1, expr=1@s2 -> succ_num=2 after s2, busy=0.
REQ-040 Scenario: trig@s0, sample_en=0 for 5 cycles, then expr=0 for 3 samples -> fail after 3rd sample, not earlier.
REQ-041 Scenario: trig@s0, sys_rst_n=0 @s1 mid-cycle -> outputs 0 immediately, no fail; SVA_FAIL_LOG_EN build: fail_cnt=1 after scenario REQ-037.
